// File: rtl/piso_ser_if.sv
// -----------------------------------------------------------------------------
// piso_ser_if
//   Bundle of the word handshake and the serial stream of piso_ser.
//
//   Handshake: a word is transferred at a rising clk edge where
//   in_valid && in_ready. The producer keeps in_data stable and in_valid high
//   until that edge; in_ready never depends on in_valid.
//
//   Signals
//     in_data   W  parallel word, captured on accept
//     in_valid  1  producer has a word
//     in_ready  1  serializer can take a word this cycle
//     d         1  serial bit, MSB first
//     d_valid   1  d carries a frame bit
//     done      1  pulse on the final bit of a frame
//     busy      1  serializer is not idle
//
//   Modports: master = word producer / stream consumer, slave = piso_ser.
// -----------------------------------------------------------------------------
interface piso_ser_if #(
   parameter int W = 8
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         d;
   logic         d_valid;
   logic         done;
   logic         busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, d, d_valid, done, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, d, d_valid, done, busy
   );
endinterface

// File: rtl/piso_ser.sv
// -----------------------------------------------------------------------------
// piso_ser
//   Parallel-in / serial-out front end for the serial sequence detectors.
//   Takes a W-bit word over a valid/ready handshake and emits it MSB first,
//   one bit per clock, on d with a d_valid qualifier. An optional idle gap of
//   GAP cycles separates frames.
//
//   Optional feature: define PISO_SER_PARITY_EN to append one even-parity bit
//   (XOR of the data bits) after the LSB, making frames W+1 bits long.
//
//   Parameters
//     W         word width, 2..32
//     GAP       idle cycles between frames, 0..15
//     IDLE_LVL  level on d while d_valid is low
//
//   Ports
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset
//     bus      piso_ser_if slave: in_data/in_valid/in_ready, d/d_valid/done/busy
//     state_o  current FSM state, for observation
// -----------------------------------------------------------------------------
module piso_ser #(
   parameter int   W        = 8,
   parameter int   GAP      = 0,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   piso_ser_if.slave   bus,
   output logic [1:0]  state_o
);

   localparam int CW = $clog2(W);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PISO_SER_PARITY_EN
   localparam logic [1:0] ST_PAR   = 2'd2;
`endif
   localparam logic [1:0] ST_GAPW  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  sr_q,    sr_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [3:0]    gcnt_q,  gcnt_d;
   logic          d_q,     d_d;
   logic          dv_q,    dv_d;
   logic          done_q,  done_d;
`ifdef PISO_SER_PARITY_EN
   logic          par_q,   par_d;
`endif

   logic final_bit;   // this cycle carries the last bit of a frame
   logic ready;
   logic accept;
   logic load;        // capture in_data and start a new frame
   logic frame_end;   // leaving the last bit of a frame

`ifdef PISO_SER_PARITY_EN
   assign final_bit = (state_q == ST_PAR);
`else
   assign final_bit = (state_q == ST_SHIFT) && (cnt_q == '0);
`endif

   // Ready is a function of state only, never of in_valid.
   assign ready = !rst &&
                  ((state_q == ST_IDLE) ||
                   (final_bit && (GAP == 0)) ||
                   ((state_q == ST_GAPW) && (gcnt_q == 4'd0)));
   assign accept = bus.in_valid && ready;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      gcnt_d    = gcnt_q;
`ifdef PISO_SER_PARITY_EN
      par_d     = par_q;
`endif
      load      = 1'b0;
      frame_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) load = 1'b1;
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               sr_d  = sr_q << 1;
               cnt_d = cnt_q - 1'b1;
            end else begin
`ifdef PISO_SER_PARITY_EN
               state_d = ST_PAR;
`else
               frame_end = 1'b1;
`endif
            end
         end
`ifdef PISO_SER_PARITY_EN
         ST_PAR: begin
            frame_end = 1'b1;
         end
`endif
         ST_GAPW: begin
            if (gcnt_q != 4'd0) gcnt_d = gcnt_q - 4'd1;
            else if (accept)    load   = 1'b1;
            else                state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Common exit after the final bit: gap, back-to-back reload, or idle.
      if (frame_end) begin
         if (GAP > 0) begin
            state_d = ST_GAPW;
            gcnt_d  = 4'(GAP - 1);
         end else if (accept) begin
            load = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end

      if (load) begin
         state_d = ST_SHIFT;
         sr_d    = bus.in_data;
         cnt_d   = CW'(W - 1);
`ifdef PISO_SER_PARITY_EN
         par_d   = ^bus.in_data;
`endif
      end

      // Stream outputs are registered: derive them from the next state so
      // the bit appears in the cycle the state is entered.
      d_d    = IDLE_LVL;
      dv_d   = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_SHIFT: begin
            d_d  = sr_d[W-1];
            dv_d = 1'b1;
`ifndef PISO_SER_PARITY_EN
            done_d = (cnt_d == '0);
`endif
         end
`ifdef PISO_SER_PARITY_EN
         ST_PAR: begin
            d_d    = par_d;
            dv_d   = 1'b1;
            done_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         gcnt_q  <= 4'd0;
         d_q     <= IDLE_LVL;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef PISO_SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         d_q     <= d_d;
         dv_q    <= dv_d;
         done_q  <= done_d;
`ifdef PISO_SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.in_ready = ready;
   assign bus.d        = d_q;
   assign bus.d_valid  = dv_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign state_o      = state_q;

endmodule

// File: tb/tb_piso_ser.sv
// -----------------------------------------------------------------------------
// tb_piso_ser
//   Two serializers side by side: GAP=0/IDLE_LVL=0 and GAP=3/IDLE_LVL=1.
//   A timeline model predicts, for every cycle, the stream bit, d_valid, done,
//   busy and in_ready from the accepts it has seen.
// -----------------------------------------------------------------------------
module tb_piso_ser;
   localparam int W = 8;
`ifdef PISO_SER_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif
   localparam int RST_AT = 47;
   localparam int N_CYC  = 1600;
   localparam int N_RAND = 50;

   typedef struct {
      int   cyc;
      logic b;
      logic last;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   piso_ser_if #(.W(W)) bus0 ();
   piso_ser_if #(.W(W)) bus1 ();
   logic [1:0] st0, st1;

   piso_ser #(.W(W), .GAP(0), .IDLE_LVL(1'b0)) u_g0 (
      .clk(clk), .rst(rst), .bus(bus0), .state_o(st0));
   piso_ser #(.W(W), .GAP(3), .IDLE_LVL(1'b1)) u_g3 (
      .clk(clk), .rst(rst), .bus(bus1), .state_o(st1));

   // ---------------- scoreboard state ----------------
   int   n_tests = 0;
   int   n_fail  = 0;
   int   gap_v[2]    = '{0, 3};
   logic idle_lvl[2] = '{1'b0, 1'b1};
   exp_t exp_q[2][$];
   int   last_end[2];
   logic [W-1:0] pend_w[2][$];
   int           pend_dly[2][$];
   logic [W-1:0] drv_data[2];
   logic         drv_valid[2];

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Push one frame whose first bit appears in cycle c+1.
   task automatic push_frame(input int id, input int c, input logic [W-1:0] w);
      exp_t e;
      for (int j = 0; j < W; j++) begin
         e.cyc  = c + 1 + j;
         e.b    = w[W-1-j];
         e.last = (FL == W) && (j == W - 1);
         exp_q[id].push_back(e);
      end
      if (FL > W) begin
         e.cyc  = c + 1 + W;
         e.b    = ^w;
         e.last = 1'b1;
         exp_q[id].push_back(e);
      end
      last_end[id] = c + FL;
   endtask

   // Compare one DUT for cycle c, then drive its inputs for the coming edge.
   task automatic step(input int id, input int c, input logic o_d,
                       input logic o_dv, input logic o_done, input logic o_busy,
                       input logic o_rdy);
      logic exp_dv, exp_d, exp_done, exp_busy, exp_rdy;
      exp_t e;
      string tg;
      tg = $sformatf("g%0d c%0d", gap_v[id], c);
      exp_dv   = (exp_q[id].size() > 0) && (exp_q[id][0].cyc == c);
      exp_d    = idle_lvl[id];
      exp_done = 1'b0;
      if (exp_dv) begin
         e        = exp_q[id].pop_front();
         exp_d    = e.b;
         exp_done = e.last;
      end
      exp_busy = exp_dv || (c > last_end[id] && c <= last_end[id] + gap_v[id]);
      exp_rdy  = !rst && (exp_q[id].size() == 0) &&
                 (exp_dv ? (gap_v[id] == 0) : (c >= last_end[id] + gap_v[id]));
      check_eq({tg, " d_valid"},  32'(o_dv),   32'(exp_dv));
      check_eq({tg, " d"},        32'(o_d),    32'(exp_d));
      check_eq({tg, " done"},     32'(o_done), 32'(exp_done));
      check_eq({tg, " busy"},     32'(o_busy), 32'(exp_busy));
      check_eq({tg, " in_ready"}, 32'(o_rdy),  32'(exp_rdy));

      // driver: idle cycles scramble in_data to show it is ignored
      drv_valid[id] = 1'b0;
      drv_data[id]  = W'($urandom);
      if (pend_w[id].size() > 0) begin
         if (pend_dly[id][0] > 0) begin
            pend_dly[id][0] = pend_dly[id][0] - 1;
         end else begin
            drv_valid[id] = 1'b1;
            drv_data[id]  = pend_w[id][0];
         end
      end
      if (drv_valid[id] && exp_rdy) begin
         push_frame(id, c, drv_data[id]);
         void'(pend_w[id].pop_front());
         void'(pend_dly[id].pop_front());
      end
   endtask

   initial begin
      logic [W-1:0] dir_w[5];
      dir_w = '{8'h98, 8'hA5, 8'h3C, 8'h07, 8'h03};
      for (int id = 0; id < 2; id++) begin
         last_end[id] = -100;
         foreach (dir_w[i]) begin
            pend_w[id].push_back(dir_w[i]);
            pend_dly[id].push_back(0);
         end
         for (int i = 0; i < N_RAND; i++) begin
            pend_w[id].push_back(W'($urandom));
            pend_dly[id].push_back(int'($urandom_range(0, 3)));
         end
      end
      bus0.in_valid = 1'b0; bus0.in_data = '0;
      bus1.in_valid = 1'b0; bus1.in_data = '0;

      for (int c = 1; c <= N_CYC; c++) begin
         @(negedge clk);
         rst = (c < 3) || (c >= RST_AT && c < RST_AT + 2);
         if (c == RST_AT + 2) begin
            // first word after the abort is all ones
            for (int id = 0; id < 2; id++) begin
               pend_w[id].push_front(8'hFF);
               pend_dly[id].push_front(0);
            end
         end
         #1;
         if (rst) begin
            // a reset aborts every frame in flight
            for (int id = 0; id < 2; id++) begin
               exp_q[id].delete();
               last_end[id] = -100;
            end
         end
         step(0, c, bus0.d, bus0.d_valid, bus0.done, bus0.busy, bus0.in_ready);
         step(1, c, bus1.d, bus1.d_valid, bus1.done, bus1.busy, bus1.in_ready);
         bus0.in_valid = drv_valid[0]; bus0.in_data = drv_data[0];
         bus1.in_valid = drv_valid[1]; bus1.in_data = drv_data[1];
      end

      // every queued word must have been sent and fully emitted
      for (int id = 0; id < 2; id++) begin
         check_eq($sformatf("g%0d words left", gap_v[id]),
                  32'(pend_w[id].size()), 32'd0);
         check_eq($sformatf("g%0d bits left", gap_v[id]),
                  32'(exp_q[id].size()), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
